bin_down_counter: RTL and testbench
===================================

Name: bin_down_counter

Overview:
- Loadable WIDTH-bit binary down counter (countdown timer) for the lab board.
- It is the counting-direction complement of the existing 1 Hz up-counter path. It counts a loaded value down to zero at TICK_HZ and flags terminal count.
- Runs entirely in the f_crystal domain. Instead of a derived slow clock, it uses an internal prescaler that produces a clock-enable tick.
- Drives LEDs or a 7-segment decoder directly; tc can start or chain other blocks.

Parameters:
- CLK_HZ, 100000000, f_crystal frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2.
- WIDTH, 4, counter width in bits.

Ports:
- f_crystal  input  1  board crystal clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  start value; captured on load.
- en  input  1  count enable; 0 freezes the prescaler and q.
- auto_reload  input  1  1 = restart from the captured value after expiry; 0 = stop at zero.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, one f_crystal cycle wide, registered.
- busy  output  1  high while in RUN.
- tick  output  1  prescaler strobe, one cycle wide, registered; exported for debug and chaining.

Behaviour:
- Reset (async, rst_n=0):
  - q=0, reload_reg=0, prescaler=0, tick=0, tc=0, state=IDLE, busy=0.
  - Takes effect immediately, including mid-count.
- Prescaler:
  - While en=1, counts 0..DIV-1.
  - At DIV-1 it wraps to 0 and drives tick=1 for the next cycle only.
  - en=0 holds the prescaler value and forces tick=0.
  - Tick period is exactly DIV cycles of continuous en.
- Load (highest priority, any state):
  - q<=load_val, reload_reg<=load_val, prescaler<=0.
  - Any tick in the same cycle is discarded; tc<=0.
  - If load_val=0, next state is IDLE; otherwise RUN.
- FSM states: IDLE, RUN, EXPIRED.
  - IDLE: q=0, busy=0. Leaves only on load with nonzero value.
  - RUN: busy=1. On tick with q>1, q<=q-1.
    - On tick with q==1: q<=0 and tc<=1, both visible the same cycle.
    - If auto_reload=1 at that tick, go to RUN-reload (below); otherwise go to EXPIRED.
  - RUN-reload: with auto_reload=1, the tick where q==0 follows the tc tick. On that tick q<=reload_reg, staying in RUN. Zero is therefore displayed for one full tick period; the count wraps N..1,0,N..
  - EXPIRED: q holds 0, busy=0, no further tc.
    - If auto_reload goes 1 while in EXPIRED, the next tick reloads and the state returns to RUN.
    - Otherwise the state is left only by load.
- No underflow: q never decrements from 0.
- tc is 0 on every cycle except the cycle after the decrementing tick edge.
- busy = (state==RUN).
- Arithmetic: unsigned, modulo 2^WIDTH. Decrement happens only when q>0.
- Simultaneous load and en=0: load still applies; the prescaler is cleared.
- Simultaneous load and tick: load wins, no decrement, no tc.

Decomposition:
- Shared include file: state encodings (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2) and the default CLK_HZ constant.
- Prescaler width is computed with $clog2(DIV) in the top module.
- One sub-module, tick_gen (parameters CLK_HZ, TICK_HZ; ports f_crystal, rst_n, en, clr, tick). It is reusable by other enable-based counters.
- FSM and count register live in bin_down_counter.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10; WIDTH=4):
- Reset then idle, en=1, no load -> q=0, busy=0, tc never asserts, tick every 10 cycles.
- load_val=3 with load, en=1, auto_reload=0:
  - q reads 3,2,1,0 at 10-cycle spacing.
  - tc is high exactly one cycle, coincident with q=0.
  - State ends in EXPIRED, busy=0, q stays 0 for 50 more cycles.
- load_val=2, auto_reload=1 -> q sequence 2,1,0,2,1,0; tc pulses once per pass, every 30 cycles.
- en deasserted mid-count at q=5 for 37 cycles -> q holds 5, tick=0; after en returns, the decrement arrives after the remaining prescaler count.
- load=1 (load_val=9) asserted on the same cycle tick would fire -> q=9, no decrement, tc=0; next decrement exactly 10 cycles later.
- rst_n pulsed low at q=6 while in RUN -> q=0, busy=0, tc=0 immediately (asynchronously); load_val=0 with load -> IDLE, no tc.

Source files
------------

// File: rtl/bin_down_counter_pkg.sv
// Shared types and defaults for the loadable down counter.
// State encoding and the default crystal frequency.
package bin_down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int DEF_CLK_HZ = 100_000_000;

endpackage

// File: rtl/tick_gen.sv
// Enable-gated prescaler producing a one-cycle registered tick
// every CLK_HZ/TICK_HZ cycles of asserted en.
module tick_gen
  import bin_down_counter_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = $clog2(CLK_HZ / TICK_HZ)
) (
  input  logic f_crystal,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge f_crystal or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/bin_down_counter.sv
// Loadable countdown timer with terminal-count pulse and optional
// auto reload, paced by an internal clock-enable prescaler.
module bin_down_counter
  import bin_down_counter_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4
) (
  input  logic             f_crystal,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic             step;
  logic             q_le1;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CNT_W   (PRE_W)
  ) u_tick_gen (
    .f_crystal (f_crystal),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (load),
    .tick      (tick)
  );

  // A load in the same cycle swallows the tick.
  assign step  = tick & en & ~load;
  assign q_le1 = (q <= WIDTH'(1));

  always_ff @(posedge f_crystal or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = (load_val == '0) ? IDLE : RUN;
    end else begin
      unique case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (step && q_le1 && !auto_reload)
            state_nxt = EXPIRED;
        end
        EXPIRED: begin
          if (step && auto_reload)
            state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge f_crystal or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q          <= load_val;
        reload_reg <= load_val;
      end else if (step) begin
        unique case (state)
          RUN: begin
            if (q > WIDTH'(1)) begin
              q <= q - 1'b1;
            end else if (q == WIDTH'(1)) begin
              q  <= '0;
              tc <= 1'b1;
            end else if (auto_reload) begin
              q <= reload_reg;
            end
          end
          EXPIRED: begin
            if (auto_reload) q <= reload_reg;
          end
          default: q <= q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bin_down_counter.sv
// Directed bench for bin_down_counter with DIV=10, WIDTH=4.
module tb_bin_down_counter;

  logic       f_crystal = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] q;
  logic       tc;
  logic       busy;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  bin_down_counter #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .WIDTH   (4)
  ) dut (
    .f_crystal   (f_crystal),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy),
    .tick        (tick)
  );

  always #5 f_crystal = ~f_crystal;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge f_crystal);
    #1;
  endtask

  logic [3:0] qs [0:70];
  logic       tcs[0:70];
  int n_tick, first_tick, n_tc, bad, tc_a, tc_b;

  initial begin
    cyc(2);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tc", tc, 0);
    chk("rst_tick", tick, 0);

    rst_n = 1'b1;
    en = 1'b1;
    n_tick = 0; first_tick = -1; n_tc = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (tick) begin
        n_tick++;
        if (first_tick < 0) first_tick = i;
      end
      if (tc) n_tc++;
      if (q != 4'd0 || busy) bad++;
    end
    chk("idle_ticks", n_tick, 4);
    chk("idle_first_tick", first_tick, 10);
    chk("idle_tc", n_tc, 0);
    chk("idle_q_busy", bad, 0);

    load = 1'b1; load_val = 4'd3; auto_reload = 1'b0;
    cyc(1);
    load = 1'b0;
    chk("ld3_q", q, 3);
    chk("ld3_busy", busy, 1);
    chk("ld3_tick", tick, 0);
    cyc(10);
    chk("ld3_q_t10", q, 3);
    cyc(1);
    chk("ld3_q_t11", q, 2);
    cyc(10);
    chk("ld3_q_t21", q, 1);
    cyc(9);
    chk("ld3_q_t30", q, 1);
    chk("ld3_tc_t30", tc, 0);
    cyc(1);
    chk("ld3_q_t31", q, 0);
    chk("ld3_tc_t31", tc, 1);
    chk("ld3_busy_t31", busy, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (q != 4'd0 || tc || busy) bad++;
    end
    chk("expired_hold", bad, 0);

    load = 1'b1; load_val = 4'd2; auto_reload = 1'b1;
    cyc(1);
    load = 1'b0;
    qs[0] = q; tcs[0] = tc;
    bad = 0; n_tc = 0; tc_a = -1; tc_b = -1;
    for (int i = 1; i <= 70; i++) begin
      cyc(1);
      qs[i] = q; tcs[i] = tc;
      if (!busy) bad++;
      if (tc) begin
        n_tc++;
        if (tc_a < 0) tc_a = i;
        else tc_b = i;
      end
    end
    chk("ar_q0", qs[0], 2);
    chk("ar_q10", qs[10], 2);
    chk("ar_q11", qs[11], 1);
    chk("ar_q21", qs[21], 0);
    chk("ar_q31", qs[31], 2);
    chk("ar_q41", qs[41], 1);
    chk("ar_q51", qs[51], 0);
    chk("ar_q61", qs[61], 2);
    chk("ar_tc_cnt", n_tc, 2);
    chk("ar_tc_first", tc_a, 21);
    chk("ar_tc_gap", tc_b - tc_a, 30);
    chk("ar_busy", bad, 0);

    auto_reload = 1'b0;
    load = 1'b1; load_val = 4'd7;
    cyc(1);
    load = 1'b0;
    chk("en_q_load", q, 7);
    cyc(21);
    chk("en_q5", q, 5);
    cyc(3);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      cyc(1);
      if (q != 4'd5 || tick) bad++;
    end
    chk("en_freeze", bad, 0);
    en = 1'b1;
    cyc(6);
    chk("en_resume_q", q, 5);
    chk("en_resume_tick", tick, 1);
    cyc(1);
    chk("en_resume_dec", q, 4);

    cyc(8);
    load = 1'b1; load_val = 4'd9;
    cyc(1);
    load = 1'b0;
    chk("col_q", q, 9);
    chk("col_tick", tick, 0);
    chk("col_tc", tc, 0);
    cyc(1);
    chk("col_no_dec", q, 9);
    cyc(9);
    chk("col_q_t10", q, 9);
    chk("col_tick_t10", tick, 1);
    cyc(1);
    chk("col_dec", q, 8);

    cyc(20);
    chk("pre_rst_q", q, 6);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tc", tc, 0);
    chk("arst_tick", tick, 0);
    cyc(2);
    rst_n = 1'b1;
    load = 1'b1; load_val = 4'd0;
    cyc(1);
    load = 1'b0;
    chk("ld0_q", q, 0);
    chk("ld0_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tc || busy || q != 4'd0) bad++;
    end
    chk("ld0_idle", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
